// File: rtl/bus_req_pkg.sv
// Shared types for the bus request issuer: FSM states, default-width request
// record and queue level width.
package bus_req_pkg;

  localparam int REQ_BUS_W   = 32;
  localparam int REQ_DATA_W  = 64;
  localparam int REQ_Q_DEPTH = 8;
  localparam int LVL_W       = $clog2(REQ_Q_DEPTH) + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } fsm_state_e;

  typedef struct packed {
    logic                  write;
    logic [REQ_BUS_W-1:0]  addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous circular-buffer FIFO; level counts 0..DEPTH inclusive.
module req_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bus_req_issuer.sv
// Queues producer read/write requests and issues them in order to design_ip as
// single-cycle sel strobes, returning read data on a valid/ready port.
module bus_req_issuer
  import bus_req_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 64,
  parameter int Q_DEPTH    = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [BUS_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [BUS_WIDTH-1:0]     addr,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic                     write,
  output logic                     sel,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic [$clog2(Q_DEPTH):0] level
);

  localparam int REQ_W = 1 + BUS_WIDTH + DATA_WIDTH;
  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  logic [REQ_W-1:0]      push_data, head;
  logic                  full, empty, push, pop;
  logic                  head_write;
  logic [BUS_WIDTH-1:0]  head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic                  rsp_free;

  fsm_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sel_q, sel_d, write_q, write_d;
  logic [BUS_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  assign push_data  = {req_write, req_addr, req_wdata};
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign head_write = head[REQ_W-1];
  assign head_addr  = head[REQ_W-2 -: BUS_WIDTH];
  assign head_wdata = head[DATA_WIDTH-1:0];

  req_fifo #(.DEPTH(Q_DEPTH), .WIDTH(REQ_W)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // A read may only leave the queue if its response can be parked.
  assign rsp_free = !rsp_valid_q || rsp_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = 1'b0;
    write_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pop         = 1'b0;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_write) begin
            pop     = 1'b1;
            sel_d   = 1'b1;
            write_d = 1'b1;
            addr_d  = head_addr;
            wdata_d = head_wdata;
          end else if (rsp_free) begin
            pop     = 1'b1;
            sel_d   = 1'b1;
            addr_d  = head_addr;
            state_d = WAIT_RD;
            cnt_d   = CNT_W'(RD_LATENCY);
          end
        end
      end
      WAIT_RD: begin
        // Counter reaches zero in the cycle design_ip drives valid rdata.
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign sel       = sel_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_req_issuer.sv
// Directed bench for bus_req_issuer with a two-cycle-latency design_ip read model.
module tb_bus_req_issuer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        write, sel;
  logic [63:0] rdata;
  logic [3:0]  level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_req_issuer dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .addr(addr), .wdata(wdata), .write(write), .sel(sel),
    .rdata(rdata), .level(level)
  );

  // design_ip read model: data valid two cycles after the sel cycle.
  function automatic logic [63:0] dip(input logic [31:0] a);
    return (a == 32'h40) ? 64'h0000_0000_DEAD_BEEF : {32'h5A5A_0000, a};
  endfunction

  logic [1:0]  rd_vld = '0;
  logic [31:0] rd_a0 = '0, rd_a1 = '0;
  always @(posedge clk) begin
    rd_vld <= {rd_vld[0], sel && !write};
    rd_a0  <= addr;
    rd_a1  <= rd_a0;
  end
  assign rdata = rd_vld[1] ? dip(rd_a1) : 64'hFFFF_FFFF_FFFF_FFFF;

  logic [32:0] mon_q[$];
  bit          mon_en = 1'b0;
  always @(negedge clk) if (mon_en && sel) mon_q.push_back({write, addr});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    step(); step();
    chk("rst_sel", sel, 0);
    chk("rst_write", write, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_level", level, 0);
    chk("rst_req_ready", req_ready, 1);
    rstn = 1'b1;
    step();

    // four back-to-back writes
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 32'h10 + i; req_wdata = 64'hA0 + i;
      step();
      if (i == 0) chk("wr_first_gap_sel", sel, 0);
      else begin
        chk("wr_sel", sel, 1);
        chk("wr_write", write, 1);
        chk("wr_addr", addr, 64'h10 + i - 1);
        chk("wr_wdata", wdata, 64'hA0 + i - 1);
      end
    end
    req_valid = 1'b0;
    step();
    chk("wr_last_sel", sel, 1);
    chk("wr_last_addr", addr, 64'h13);
    chk("wr_last_wdata", wdata, 64'hA3);
    chk("wr_level", level, 0);
    step();
    chk("idle_sel", sel, 0);
    chk("idle_write", write, 0);
    chk("idle_addr_hold", addr, 64'h13);
    chk("idle_wdata_hold", wdata, 64'hA3);

    // single read 0x40
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = 64'h1234;
    step();
    req_valid = 1'b0;
    chk("rd_gap_sel", sel, 0);
    step();
    chk("rd_sel", sel, 1);
    chk("rd_write", write, 0);
    chk("rd_addr", addr, 64'h40);
    step(); chk("rd_t1_rsp", rsp_valid, 0);
    step(); chk("rd_t2_rsp", rsp_valid, 0);
    step();
    chk("rd_t3_rsp", rsp_valid, 1);
    chk("rd_data", rsp_rdata, 64'hDEAD_BEEF);
    step();
    chk("rd_hold_valid", rsp_valid, 1);
    chk("rd_hold_data", rsp_rdata, 64'hDEAD_BEEF);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_clear", rsp_valid, 0);

    // read, write, read with consumer stalled
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50;
    step();
    req_write = 1'b1; req_addr = 32'h60; req_wdata = 64'hB6;
    step();
    chk("rwr_r1_sel", sel, 1);
    chk("rwr_r1_write", write, 0);
    chk("rwr_r1_addr", addr, 64'h50);
    req_write = 1'b0; req_addr = 32'h70;
    step();
    req_valid = 1'b0;
    chk("rwr_level", level, 2);
    chk("rwr_wait_sel", sel, 0);
    step();
    step();
    chk("rwr_r1_rsp", rsp_valid, 1);
    chk("rwr_r1_data", rsp_rdata, {32'h5A5A_0000, 32'h50});
    step();
    chk("rwr_w_sel", sel, 1);
    chk("rwr_w_write", write, 1);
    chk("rwr_w_addr", addr, 64'h60);
    chk("rwr_w_wdata", wdata, 64'hB6);
    chk("rwr_w_rsp_pending", rsp_valid, 1);
    step();
    chk("rwr_r2_stall_sel", sel, 0);
    chk("rwr_r2_stall_level", level, 1);
    step();
    chk("rwr_r2_stall_sel2", sel, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rwr_r2_sel", sel, 1);
    chk("rwr_r2_write", write, 0);
    chk("rwr_r2_addr", addr, 64'h70);
    chk("rwr_r1_cleared", rsp_valid, 0);
    step(); step(); step();
    chk("rwr_r2_rsp", rsp_valid, 1);
    chk("rwr_r2_data", rsp_rdata, {32'h5A5A_0000, 32'h70});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // fill queue behind a pending response
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h80;
    step();
    req_valid = 1'b0;
    step(); step(); step(); step();
    chk("fill_pending", rsp_valid, 1);
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h90 + i;
      step();
      chk("fill_level", level, i + 1);
    end
    chk("fill_ready", req_ready, 0);
    req_addr = 32'h98;
    step();
    chk("full_hold_level", level, 8);
    step();
    chk("full_hold_level2", level, 8);
    chk("full_hold_ready", req_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("full_pop_level", level, 7);
    chk("full_pop_sel", sel, 1);
    chk("full_pop_addr", addr, 64'h90);
    step();
    req_valid = 1'b0;
    chk("ninth_accepted", level, 8);
    step();

    // reset while WAIT_RD
    rstn = 1'b0;
    #1;
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_addr", addr, 0);
    step(); step();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_rsp", rsp_valid, 0);
      chk("post_rst_sel", sel, 0);
    end

    // 20 mixed requests across pointer wrap
    rsp_ready = 1'b1;
    mon_q.delete();
    mon_en = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h200; req_wdata = 64'hC00;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 1; i < 20; i++) begin
      int n;
      req_valid = 1'b1; req_write = (i % 4 != 0);
      req_addr = 32'h200 + i; req_wdata = 64'hC00 + i;
      n = 0;
      while (!req_ready && n < 50) begin step(); n++; end
      chk("wrap_push_ready", req_ready, 1);
      step();
      if (i == 4) begin
        chk("pushpop_level", level, 3);
        chk("pushpop_sel", sel, 1);
        chk("pushpop_addr", addr, 64'h201);
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 100 && level != 0; k++) step();
    for (int k = 0; k < 8; k++) step();
    chk("wrap_drained", level, 0);
    mon_en = 1'b0;
    chk("wrap_count", mon_q.size(), 20);
    for (int i = 0; i < 20; i++) begin
      logic [32:0] exp_e;
      exp_e = {(i % 4 != 0) ? 1'b1 : 1'b0, 32'h200 + i};
      if (i < mon_q.size()) chk("wrap_order", mon_q[i], exp_e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
